fifo_sync_ctl: RTL and testbench
================================

Name: fifo_sync_ctl

Overview:
- Parametrised single-clock FIFO; the next-generation buffer between the UART TX host-side write logic and the serialiser.
- Adds over the existing FIFO:
  - occupancy count
  - programmable almost-full / almost-empty thresholds
  - synchronous flush
  - sticky overflow/underflow error flags
  - push-on-full when a pop happens in the same cycle
  - optional first-word-fall-through read mode
- Storage is a flat register array; no vendor RAM.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  push request.
- d_in  in  WIDTH  push data.
- rd_en  in  1  pop request.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  synchronous clear of the sticky error flags.
- d_out  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a push was rejected.
- underflow  out  1  sticky: a pop was rejected.

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits and wrap naturally modulo 2*DEPTH.
  - The low bits index memory.
  - full/empty are decoded as MSB-differ/equal of the two pointers.
  - count = wr_ptr - rd_ptr, registered and consistent with the pointers every cycle.
- Reset (rst_n low, asynchronous), output values:
  - pointers, count = 0; d_out = 0
  - empty = 1, almost_empty = 1; full = 0, almost_full = 0 (AF_LEVEL >= 1)
  - overflow = 0, underflow = 0
  - Memory contents are not reset.
  - Reset asserted mid-transfer discards all data; the first cycle after release behaves as an empty FIFO.
- Accept rules, evaluated on the pre-edge state:
  - pop_ok = rd_en && !empty
  - push_ok = wr_en && (!full || pop_ok)
- Simultaneous events:
  - When full, a push and a valid pop in the same cycle both complete; count is unchanged.
  - When empty, a simultaneous push and pop gives: push accepted, pop rejected, underflow set, count becomes 1.
- Count update:
  - count +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH or goes below 0.
- Errors:
  - wr_en && !push_ok sets overflow.
  - rd_en && !pop_ok sets underflow.
  - Both flags hold until clr_err or reset.
  - If clr_err coincides with a new error in the same cycle, the set wins.
- flush (highest priority after reset):
  - Next edge: rd_ptr <= wr_ptr value after flush forced to match; both pointers and count go to 0, empty = 1.
  - Any push or pop in the same cycle is ignored and raises no error flag.
  - d_out holds its last value.
- Standard read mode (macro absent):
  - d_out is registered, loaded with mem[rd_ptr] on the edge where pop_ok is true, so data is valid 1 cycle after rd_en.
  - d_out holds otherwise.
- Flag and data timing:
  - All flags are registered, or derived combinationally from registered pointers.
  - No combinational path exists from wr_en/rd_en to any flag or data output.

Optional Feature:
- Macro FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - d_out continuously presents mem[rd_ptr]; rd_en acknowledges and advances.
  - A word written into an empty FIFO appears on d_out 1 cycle after the write edge, with empty deasserted in the same cycle.
  - d_out is undefined-but-stable while empty; the d_out reset value does not apply.
- Undefined: standard registered read with 1-cycle latency as specified above.
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - function ptr_w(depth) returning $clog2(depth)+1
  - default WIDTH/DEPTH constants
  - an elaboration-time check that DEPTH is a power of two and that AF_LEVEL and AE_LEVEL are in range
- One natural sub-module, fifo_mem: WIDTH x DEPTH register array with one write port and one read port.
  - Write port: we, waddr, wdata.
  - Read port: raddr, rdata, asynchronous read.
- Pointer, flag, count and error logic stay in fifo_sync_ctl.

Test Plan:
- Reset, then write 0x11..0x20 (16 words).
  - Required: count 1..16; almost_full at 14; full at 16; no overflow.
  - Then 16 reads return 0x11..0x20 in order; empty at end; almost_empty at count 2.
- Full FIFO, wr_en=1 with rd_en=0 for 1 cycle -> overflow=1, count stays 16, contents unchanged; clr_err -> overflow=0.
- Full FIFO, wr_en=1 with rd_en=1 writing 0xA5 -> count stays 16, oldest word popped, 0xA5 read back as the 16th word.
- Empty FIFO:
  - rd_en=1 alone -> underflow=1, d_out unchanged.
  - Then wr_en and rd_en together -> count=1, underflow stays set.
- Write 5 words, then flush with wr_en=1 in the same cycle -> count=0, empty=1, no error; a subsequent write and read returns only the new word.
- 40 writes and 40 reads interleaved, crossing pointer wrap twice -> data order preserved, count never out of range.
- Rerun the whole plan with FIFO_FWFT_EN defined: d_out shows the head word 1 cycle after the first write, with zero read latency.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the synchronous FIFO controller.
// The FIFO_FWFT_EN macro selects first-word-fall-through reads in fifo_sync_ctl.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 16;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic params_ok(input int unsigned depth,
                                     input int unsigned af_level,
                                     input int unsigned ae_level);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_level >= 1) && (af_level <= depth) &&
           (ae_level <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_ctl.sv
// Single-clock FIFO controller: pointers, occupancy, thresholds, flush and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module fifo_sync_ctl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          d_in,
  input  logic                      rd_en,
  input  logic                      flush,
  input  logic                      clr_err,
  output logic [WIDTH-1:0]          d_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  if (!params_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_param_check
    $error("fifo_sync_ctl: DEPTH must be a power of two >= 2, AF_LEVEL in 1..DEPTH, AE_LEVEL in 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             pop_ok, push_ok;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign pop_ok  = rd_en && !empty;
  assign push_ok = wr_en && (!full || pop_ok);
  assign mem_we  = push_ok && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
      if (wr_en && !push_ok) ovf_d = 1'b1;
      if (rd_en && !pop_ok)  udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (d_in),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  assign d_out = mem_rdata;
`else
  logic [WIDTH-1:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (pop_ok && !flush) dout_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign d_out = dout_q;
`endif

  assign count        = count_q;
  assign almost_full  = (count_q >= PW'(AF_LEVEL));
  assign almost_empty = (count_q <= PW'(AE_LEVEL));
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_ctl.sv
// Directed, table-driven bench for fifo_sync_ctl (both default and FIFO_FWFT_EN builds).
module tb_fifo_sync_ctl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en, flush, clr_err;
  logic [7:0] d_in, d_out;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       wr, rd, fl, clr;
    logic [7:0] din;
    int         cnt;
    logic       ovf, udf;
    logic [7:0] dstd;
    logic       chk_fw;
    logic [7:0] dfw;
  } vec_t;

  vec_t vecs[$];

  fifo_sync_ctl #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .d_in         (d_in),
    .rd_en        (rd_en),
    .flush        (flush),
    .clr_err      (clr_err),
    .d_out        (d_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic void add(input int wr, input int rd, input int fl, input int clr,
                              input int din, input int cnt, input int ovf, input int udf,
                              input int dstd, input int chk_fw, input int dfw);
    vec_t v;
    v.wr = wr[0]; v.rd = rd[0]; v.fl = fl[0]; v.clr = clr[0];
    v.din = 8'(din); v.cnt = cnt; v.ovf = ovf[0]; v.udf = udf[0];
    v.dstd = 8'(dstd); v.chk_fw = chk_fw[0]; v.dfw = 8'(dfw);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: actual 0x%0h, required 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic fl, input logic clr,
                       input logic [7:0] din);
    wr_en = wr; rd_en = rd; flush = fl; clr_err = clr; d_in = din;
    @(posedge clk);
    #1;
  endtask

  // {empty, full, almost_full, almost_empty, overflow, underflow}
  function automatic int flags_exp(input int cnt, input logic ovf, input logic udf);
    logic [5:0] f;
    f = {cnt == 0, cnt == 16, cnt >= 14, cnt <= 2, ovf, udf};
    return int'(f);
  endfunction

  function automatic int flags_act();
    logic [5:0] f;
    f = {empty, full, almost_full, almost_empty, overflow, underflow};
    return int'(f);
  endfunction

  initial begin
    int s;
    vec_t v;

    // Fill 0x11..0x20 to full, then overflow, clear, push-on-full with pop.
    s = 0;
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 'h11 + i, i + 1, 0, 0, s, 1, 'h11);
    add(1, 0, 0, 0, 'hEE, 16, 1, 0, s, 1, 'h11);
    add(0, 0, 0, 1, 0, 16, 0, 0, s, 1, 'h11);
    s = 'h11;
    add(1, 1, 0, 0, 'hA5, 16, 0, 0, s, 1, 'h12);
    for (int i = 0; i < 15; i++) begin
      s = 'h12 + i;
      add(0, 1, 0, 0, 0, 15 - i, 0, 0, s, 1, (i < 14) ? 'h13 + i : 'hA5);
    end
    s = 'hA5;
    add(0, 1, 0, 0, 0, 0, 0, 0, s, 0, 0);
    // Empty: pop alone, then push+pop together.
    add(0, 1, 0, 0, 0, 0, 0, 1, s, 0, 0);
    add(1, 1, 0, 0, 'h3C, 1, 0, 1, s, 1, 'h3C);
    add(0, 0, 0, 1, 0, 1, 0, 0, s, 1, 'h3C);
    s = 'h3C;
    add(0, 1, 0, 0, 0, 0, 0, 0, s, 0, 0);
    // Five words, then flush with a concurrent push (and a flush on empty with push+pop).
    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 'h51 + i, i + 1, 0, 0, s, 1, 'h51);
    add(1, 0, 1, 0, 'h99, 0, 0, 0, s, 0, 0);
    add(1, 1, 1, 0, 'h9A, 0, 0, 0, s, 0, 0);
    add(1, 0, 0, 0, 'h77, 1, 0, 0, s, 1, 'h77);
    s = 'h77;
    add(0, 1, 0, 0, 0, 0, 0, 0, s, 0, 0);
    // 40 writes / 40 reads in bursts of four, wrapping the pointers.
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 4; j++) add(1, 0, 0, 0, 'h80 + 4*r + j, j + 1, 0, 0, s, 1, 'h80 + 4*r);
      for (int j = 0; j < 4; j++) begin
        s = 'h80 + 4*r + j;
        add(0, 1, 0, 0, 0, 3 - j, 0, 0, s, (j < 3) ? 1 : 0, 'h80 + 4*r + j + 1);
      end
    end
    // Full and empty again from a non-zero pointer offset.
    for (int i = 0; i < 16; i++) add(1, 0, 0, 0, 'hC0 + i, i + 1, 0, 0, s, 1, 'hC0);
    for (int i = 0; i < 16; i++) begin
      s = 'hC0 + i;
      add(0, 1, 0, 0, 0, 15 - i, 0, 0, s, (i < 15) ? 1 : 0, 'hC1 + i);
    end

    rst_n = 1'b0; wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; d_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset count", -1, int'(count), 0);
    chk("reset flags", -1, flags_act(), flags_exp(0, 1'b0, 1'b0));
`ifndef FIFO_FWFT_EN
    chk("reset d_out", -1, int'(d_out), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      drive(v.wr, v.rd, v.fl, v.clr, v.din);
      chk("count", k, int'(count), v.cnt);
      chk("flags", k, flags_act(), flags_exp(v.cnt, v.ovf, v.udf));
`ifdef FIFO_FWFT_EN
      if (v.chk_fw) chk("d_out", k, int'(d_out), int'(v.dfw));
`else
      chk("d_out", k, int'(d_out), int'(v.dstd));
`endif
    end

    // Reset asserted mid-transfer with data held and an error flag set.
    drive(0, 1, 0, 0, 8'h00);
    chk("pre-reset underflow", 0, int'(underflow), 1);
    drive(1, 0, 0, 0, 8'hD1);
    drive(1, 0, 0, 0, 8'hD2);
    drive(1, 0, 0, 0, 8'hD3);
    chk("pre-reset count", 0, int'(count), 3);
    wr_en = 0; rd_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset count", 0, int'(count), 0);
    chk("async reset flags", 0, flags_act(), flags_exp(0, 1'b0, 1'b0));
`ifndef FIFO_FWFT_EN
    chk("async reset d_out", 0, int'(d_out), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 8'h00);
    chk("post-reset pop count", 0, int'(count), 0);
    chk("post-reset pop flags", 0, flags_act(), flags_exp(0, 1'b0, 1'b1));
`ifndef FIFO_FWFT_EN
    chk("post-reset pop d_out", 0, int'(d_out), 0);
`endif
    drive(0, 0, 0, 1, 8'h00);
    drive(1, 0, 0, 0, 8'h42);
    chk("post-reset write count", 0, int'(count), 1);
`ifdef FIFO_FWFT_EN
    chk("post-reset fwft d_out", 0, int'(d_out), 'h42);
`endif
    drive(0, 1, 0, 0, 8'h00);
    chk("post-reset read count", 0, int'(count), 0);
`ifndef FIFO_FWFT_EN
    chk("post-reset read d_out", 0, int'(d_out), 'h42);
`endif
    chk("post-reset final flags", 0, flags_act(), flags_exp(0, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
